// File: rtl/aes_ctr_pipe.sv
// aes_ctr_pipe: fully unrolled AES-128/192/256 pipeline with GCM inc32 counter, tag sideband and global stall
module aes_ctr_pipe #(
    parameter int NR = 14,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [128*(NR+1)-1:0] round_keys_flat,
    input  logic                  ctr_load,
    input  logic [127:0]          iv_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_sel,
    input  logic [127:0]          blk_in,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [127:0]          ks_data,
    output logic [TAG_W-1:0]      ks_tag,
    output logic [127:0]          ks_ctr
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_ctr_pipe: NR must be 10, 12 or 14");
    end

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // byte n of the state sits at [127-8n -: 8]; column n/4, row n%4
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k);
        return mix(sub_shift(s)) ^ k;
    endfunction

    function automatic logic [127:0] inc32(input logic [127:0] x);
        return {x[127:32], x[31:0] + 32'd1};
    endfunction

    logic adv;
    logic accept;
    logic [127:0] ctr;
    logic [127:0] blk;
    logic [NR-1:0] st_valid;
    logic [127:0] st_data [NR];
    logic [127:0] st_ctr [NR];
    logic [TAG_W-1:0] st_tag [NR];

    assign adv = !(ks_valid && !ks_ready);
    assign req_ready = adv;
    assign accept = req_valid && adv;
    assign blk = req_sel ? blk_in : (ctr_load ? iv_in : ctr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctr <= '0;
        else if (accept && !req_sel) ctr <= inc32(blk);
        else if (ctr_load) ctr <= iv_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= '0;
            ks_valid <= 1'b0;
            ks_data <= '0;
            ks_tag <= '0;
            ks_ctr <= '0;
        end else if (adv) begin
            st_valid <= {st_valid[NR-2:0], accept};
            ks_valid <= st_valid[NR-1];
            ks_data <= sub_shift(st_data[NR-1]) ^ round_keys_flat[128*NR +: 128];
            ks_tag <= st_tag[NR-1];
            ks_ctr <= st_ctr[NR-1];
        end
    end

    // datapath stages are unreset; st_valid qualifies them
    always_ff @(posedge clk) begin
        if (adv) begin
            st_data[0] <= blk ^ round_keys_flat[127:0];
            st_tag[0] <= req_tag;
            st_ctr[0] <= blk;
            for (int i = 1; i < NR; i++) begin
                st_data[i] <= aes_round(st_data[i-1], round_keys_flat[128*i +: 128]);
                st_tag[i] <= st_tag[i-1];
                st_ctr[i] <= st_ctr[i-1];
            end
        end
    end
endmodule

// File: tb/tb_aes_ctr_pipe.sv
// tb_aes_ctr_pipe: directed + randomized checks of aes_ctr_pipe against a byte-level AES/GCM-counter model
module tb_aes_ctr_pipe;
    localparam int NR = 14;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   tag;
        logic [127:0] ctr;
        int           acc;
        bit           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [128*15-1:0] rk14;
    logic ctr_load, req_valid, req_ready, req_sel, ks_valid, ks_ready;
    logic [127:0] iv_in, blk_in, ks_data, ks_ctr;
    logic [7:0] req_tag, ks_tag;

    logic [128*11-1:0] t_rk;
    logic t_req_valid, t_req_ready, t_ks_valid;
    logic [127:0] t_blk, t_ks_data, t_ks_ctr;
    logic [7:0] t_tag, t_ks_tag;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int issued = 0;
    bit lat_mode = 1'b1;
    logic [127:0] m_ctr = '0;
    logic [7:0] sb [256];
    exp_t q[$];
    logic [127:0] log_ctr[$];
    logic [7:0] log_tag[$];

    logic [255:0] key;
    logic [128*15-1:0] rkf;
    logic [127:0] iv, iv2, bb;
    int n;

    always #5 clk = ~clk;

    aes_ctr_pipe #(.NR(14), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .round_keys_flat(rk14), .ctr_load(ctr_load), .iv_in(iv_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .blk_in(blk_in),
        .req_tag(req_tag), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .ks_tag(ks_tag), .ks_ctr(ks_ctr)
    );

    aes_ctr_pipe #(.NR(10), .TAG_W(8)) dut10 (
        .clk(clk), .rst(rst), .round_keys_flat(t_rk), .ctr_load(1'b0), .iv_in(128'h0),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_sel(1'b1), .blk_in(t_blk),
        .req_tag(t_tag), .ks_valid(t_ks_valid), .ks_ready(1'b1), .ks_data(t_ks_data),
        .ks_tag(t_ks_tag), .ks_ctr(t_ks_ctr)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
    function automatic logic [7:0] sb_calc(input logic [7:0] b);
        logic [7:0] inv, y;
        inv = 8'h00;
        for (int x = 1; x < 256; x++) if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
        y = inv;
        for (int k = 1; k < 5; k++) y = y ^ ((inv << k) | (inv >> (8 - k)));
        return y ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [128*15-1:0] expand(input logic [255:0] k, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [128*15-1:0] rk;
        rc = 8'h01;
        rk = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) w[i] = k[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) t = sub_word(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++) rk[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return rk;
    endfunction

    function automatic logic [127:0] enc(input logic [128*15-1:0] rk, input int nr, input logic [127:0] b);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = b[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
            if (r < nr)
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) t[k] = s[4*c+k];
                    for (int k = 0; k < 4; k++)
                        s[4*c+k] = gmul(8'h02, t[k]) ^ gmul(8'h03, t[(k+1)%4]) ^ t[(k+2)%4] ^ t[(k+3)%4];
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[128*r+127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // runs at the falling edge: scores the output handshake, then records any accepted request
    task automatic monitor();
        exp_t e;
        logic [127:0] b;
        chk("req_ready", req_ready, !(ks_valid && !ks_ready));
        if (ks_valid) begin
            if (q.size() == 0) chk("spurious_valid", ks_valid, 1'b0);
            else begin
                chk("ks_data", ks_data, q[0].data);
                chk("ks_tag", ks_tag, q[0].tag);
                chk("ks_ctr", ks_ctr, q[0].ctr);
                if (ks_ready) begin
                    if (q[0].lat) chk("latency", cyc - q[0].acc, NR + 1);
                    log_ctr.push_back(ks_ctr);
                    log_tag.push_back(ks_tag);
                    void'(q.pop_front());
                end
            end
        end
        if (req_valid && req_ready) begin
            b = req_sel ? blk_in : (ctr_load ? iv_in : m_ctr);
            e.data = enc(rk14, NR, b);
            e.tag = req_tag;
            e.ctr = b;
            e.acc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
            issued++;
            if (!req_sel) m_ctr = {b[127:32], b[31:0] + 32'd1};
            else if (ctr_load) m_ctr = iv_in;
        end else if (ctr_load) m_ctr = iv_in;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        ks_ready = 1'b1;
        req_valid = 1'b0;
        ctr_load = 1'b0;
        for (int g = 0; g < 60 && q.size() > 0; g++) tick();
        tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        ctr_load = 1'b0; iv_in = '0; req_valid = 1'b0; req_sel = 1'b0; blk_in = '0; req_tag = '0; ks_ready = 1'b1;
        t_req_valid = 1'b0; t_blk = '0; t_tag = '0; t_rk = '0;
        for (int b = 0; b < 256; b++) sb[b] = sb_calc(8'(b));
        key = '0;
        for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
        rk14 = expand(key, 8, 14);
        #3;
        chk("rst_ks_valid", ks_valid, 1'b0);
        chk("rst_ks_data", ks_data, 128'h0);
        chk("rst_ks_tag", ks_tag, 8'h0);
        chk("rst_ks_ctr", ks_ctr, 128'h0);
        chk("rst_t_ks_valid", t_ks_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // AES-256 known answer and latency
        blk_in = 128'h00112233445566778899aabbccddeeff; req_sel = 1'b1; req_tag = 8'ha5; req_valid = 1'b1;
        chk("accept_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!ks_valid && n < 40) begin tick(); n++; end
        chk("lat14", n, 15);
        chk("kat256", ks_data, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk("kat256_tag", ks_tag, 8'ha5);
        drain();

        // AES-128 known answers on the NR=10 instance
        key = '0;
        for (int i = 0; i < 16; i++) key[255-8*i -: 8] = 8'(i);
        rkf = expand(key, 4, 10);
        t_rk = rkf[128*11-1:0];
        t_blk = 128'h00112233445566778899aabbccddeeff; t_tag = 8'h3c; t_req_valid = 1'b1;
        chk("t_ready", t_req_ready, 1'b1);
        tick();
        t_req_valid = 1'b0;
        n = 1;
        while (!t_ks_valid && n < 40) begin tick(); n++; end
        chk("lat10", n, 11);
        chk("kat128", t_ks_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("kat128_model", t_ks_data, enc(rkf, 10, t_blk));
        chk("kat128_tag", t_ks_tag, 8'h3c);
        chk("kat128_ctr", t_ks_ctr, t_blk);
        tick();
        rkf = expand(256'h0, 4, 10);
        t_rk = rkf[128*11-1:0];
        t_blk = '0; t_req_valid = 1'b1;
        tick();
        t_req_valid = 1'b0;
        n = 1;
        while (!t_ks_valid && n < 40) begin tick(); n++; end
        chk("gcm_h", t_ks_data, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        tick();

        // inc32 wrap: no carry into the upper 96 bits
        log_ctr.delete(); log_tag.delete();
        iv = {$urandom, $urandom, $urandom, 32'hFFFFFFFE};
        ctr_load = 1'b1; iv_in = iv; req_valid = 1'b0;
        tick();
        ctr_load = 1'b0; req_valid = 1'b1; req_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin req_tag = 8'(16 + i); tick(); end
        drain();
        chk("wrap_count", log_ctr.size(), 3);
        if (log_ctr.size() == 3) begin
            chk("wrap0", log_ctr[0], iv);
            chk("wrap1", log_ctr[1], {iv[127:32], 32'hFFFFFFFF});
            chk("wrap2", log_ctr[2], {iv[127:32], 32'h00000000});
        end

        // ctr_load coinciding with counter and ECB accepts
        log_ctr.delete(); log_tag.delete();
        iv = {$urandom, $urandom, $urandom, $urandom};
        iv2 = {$urandom, $urandom, $urandom, $urandom};
        bb = {$urandom, $urandom, $urandom, $urandom};
        ctr_load = 1'b1; iv_in = iv; req_valid = 1'b1; req_sel = 1'b0; req_tag = 8'h30;
        tick();
        ctr_load = 1'b0; req_tag = 8'h31;
        tick();
        ctr_load = 1'b1; iv_in = iv2; req_sel = 1'b1; blk_in = bb; req_tag = 8'h32;
        tick();
        ctr_load = 1'b0; req_sel = 1'b0; req_tag = 8'h33;
        tick();
        drain();
        chk("load_count", log_ctr.size(), 4);
        if (log_ctr.size() == 4) begin
            chk("load_accept", log_ctr[0], iv);
            chk("load_next", log_ctr[1], {iv[127:32], iv[31:0] + 32'd1});
            chk("load_ecb", log_ctr[2], bb);
            chk("load_ecb_next", log_ctr[3], iv2);
        end

        // random stream with random back-pressure
        log_ctr.delete(); log_tag.delete();
        lat_mode = 1'b0; issued = 0;
        for (int g = 0; g < 400 && issued < 20; g++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_sel = ($urandom_range(0, 4) == 0);
            blk_in = {$urandom, $urandom, $urandom, $urandom};
            req_tag = 8'(issued);
            ctr_load = ($urandom_range(0, 15) == 0);
            iv_in = {$urandom, $urandom, $urandom, $urandom};
            ks_ready = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = 1'b0; ctr_load = 1'b0;
        for (int g = 0; g < 400 && q.size() > 0; g++) begin ks_ready = 1'($urandom_range(0, 1)); tick(); end
        chk("stream_empty", q.size(), 0);
        chk("stream_count", log_tag.size(), 20);
        for (int i = 0; i < log_tag.size(); i++) chk("stream_order", log_tag[i], i);
        drain();
        lat_mode = 1'b1;

        // asynchronous reset with 5 blocks in flight
        req_valid = 1'b1; req_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin req_tag = 8'(64 + i); tick(); end
        req_valid = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", ks_valid, 1'b0);
        chk("arst_data", ks_data, 128'h0);
        chk("arst_tag", ks_tag, 8'h0);
        chk("arst_ctr", ks_ctr, 128'h0);
        q.delete();
        m_ctr = '0;
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < NR + 2; i++) begin tick(); chk("no_stale", ks_valid, 1'b0); end
        log_ctr.delete(); log_tag.delete();
        req_valid = 1'b1; req_sel = 1'b0; req_tag = 8'h77;
        tick();
        drain();
        chk("post_rst_count", log_ctr.size(), 1);
        if (log_ctr.size() == 1) chk("post_rst_ctr", log_ctr[0], 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
